// File: rtl/gcd_arb_pkg.sv
// Shared types for the gcd arbiter slice: FSM encoding,
// default datapath width and the requester id type.
package gcd_arb_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef logic reqId_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_RESULT = 2'd2,
        DELIVER     = 2'd3
    } state_t;

endpackage

// File: rtl/gcd_rr_pick.sv
// Two-way round-robin select: a lone requester wins,
// a tie goes to whichever requester the pointer names.
module gcd_rr_pick
    import gcd_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic grantValid,
    output logic grantId
);

    // pick the winner for this cycle
    always_comb begin
        grantValid = req0 | req1;
        grantId    = 1'b0;
        if (req0 && req1) begin
            grantId = pointer;
        end else if (req1) begin
            grantId = 1'b1;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one gcd unit between two requesters, one job
// in flight, round-robin on ties, all outputs registered.
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clockInput,
    input  logic             resetInput,
    input  logic             r0IsReadyInput,
    input  logic [WIDTH-1:0] r0ADataInput,
    input  logic [WIDTH-1:0] r0BDataInput,
    output logic             r0AckOutput,
    output logic             r0ResultReadyOutput,
    output logic [WIDTH-1:0] r0ResultDataOutput,
    input  logic             r0ResultAckInput,
    input  logic             r1IsReadyInput,
    input  logic [WIDTH-1:0] r1ADataInput,
    input  logic [WIDTH-1:0] r1BDataInput,
    output logic             r1AckOutput,
    output logic             r1ResultReadyOutput,
    output logic [WIDTH-1:0] r1ResultDataOutput,
    input  logic             r1ResultAckInput,
    output logic             gcdAIsReadyOutput,
    output logic [WIDTH-1:0] gcdADataOutput,
    input  logic             gcdAAckInput,
    output logic             gcdBIsReadyOutput,
    output logic [WIDTH-1:0] gcdBDataOutput,
    input  logic             gcdBAckInput,
    input  logic             gcdOutReadyInput,
    input  logic [WIDTH-1:0] gcdOutDataInput,
    output logic             gcdOutAckOutput
);

    state_t           state, stateNext;
    reqId_t           owner, ownerNext;
    reqId_t           pointer, pointerNext;
    logic [1:0]       reqAck, reqAckNext;
    logic [1:0]       resReady, resReadyNext;
    logic [WIDTH-1:0] res0Data, res0DataNext;
    logic [WIDTH-1:0] res1Data, res1DataNext;
    logic             aReady, aReadyNext;
    logic             bReady, bReadyNext;
    logic [WIDTH-1:0] aData, aDataNext;
    logic [WIDTH-1:0] bData, bDataNext;
    logic             outAck, outAckNext;
    logic             pickValid;
    logic             pickId;
    logic             ownerResAck;
    logic             newResult;

    gcd_rr_pick u_pick (
        .req0       (r0IsReadyInput),
        .req1       (r1IsReadyInput),
        .pointer    (pointer),
        .grantValid (pickValid),
        .grantId    (pickId)
    );

    assign r0AckOutput         = reqAck[0];
    assign r1AckOutput         = reqAck[1];
    assign r0ResultReadyOutput = resReady[0];
    assign r1ResultReadyOutput = resReady[1];
    assign r0ResultDataOutput  = res0Data;
    assign r1ResultDataOutput  = res1Data;
    assign gcdAIsReadyOutput   = aReady;
    assign gcdBIsReadyOutput   = bReady;
    assign gcdADataOutput      = aData;
    assign gcdBDataOutput      = bData;
    assign gcdOutAckOutput     = outAck;

    // only the owner's result ack counts
    assign ownerResAck = owner ? r1ResultAckInput : r0ResultAckInput;
    // a result still high under our own ack is the old one
    assign newResult   = gcdOutReadyInput && !outAck;

    // next-state and next-output decode
    always_comb begin
        stateNext    = state;
        ownerNext    = owner;
        pointerNext  = pointer;
        reqAckNext   = 2'b00;
        outAckNext   = 1'b0;
        resReadyNext = resReady;
        res0DataNext = res0Data;
        res1DataNext = res1Data;
        aReadyNext   = aReady;
        bReadyNext   = bReady;
        aDataNext    = aData;
        bDataNext    = bData;
        unique case (state)
            IDLE: begin
                if (gcdOutReadyInput) begin
                    outAckNext = newResult;
                end else if (pickValid) begin
                    ownerNext           = pickId;
                    reqAckNext[pickId]  = 1'b1;
                    aReadyNext          = 1'b1;
                    bReadyNext          = 1'b1;
                    aDataNext = pickId ? r1ADataInput : r0ADataInput;
                    bDataNext = pickId ? r1BDataInput : r0BDataInput;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (gcdAAckInput) aReadyNext = 1'b0;
                if (gcdBAckInput) bReadyNext = 1'b0;
                if (!aReadyNext && !bReadyNext) begin
                    stateNext = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                if (newResult) begin
                    outAckNext      = 1'b1;
                    resReadyNext[owner] = 1'b1;
                    if (owner) res1DataNext = gcdOutDataInput;
                    else       res0DataNext = gcdOutDataInput;
                    stateNext = DELIVER;
                end
            end
            DELIVER: begin
                if (ownerResAck) begin
                    resReadyNext[owner] = 1'b0;
                    pointerNext = ~owner;
                    stateNext   = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clockInput or negedge resetInput) begin
        if (!resetInput) begin
            state    <= IDLE;
            owner    <= 1'b0;
            pointer  <= 1'b0;
            reqAck   <= 2'b00;
            outAck   <= 1'b0;
            resReady <= 2'b00;
            res0Data <= '0;
            res1Data <= '0;
            aReady   <= 1'b0;
            bReady   <= 1'b0;
            aData    <= '0;
            bData    <= '0;
        end else begin
            state    <= stateNext;
            owner    <= ownerNext;
            pointer  <= pointerNext;
            reqAck   <= reqAckNext;
            outAck   <= outAckNext;
            resReady <= resReadyNext;
            res0Data <= res0DataNext;
            res1Data <= res1DataNext;
            aReady   <= aReadyNext;
            bReady   <= bReadyNext;
            aData    <= aDataNext;
            bData    <= bDataNext;
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: requester and gcd-unit
// responders plus hand-computed expectations per scenario.
module tb_gcd_arbiter;
    import gcd_arb_pkg::*;

    localparam int W = 32;

    logic              clockInput = 1'b0;
    logic              resetInput;
    logic [1:0]        isReady;
    logic [1:0][W-1:0] aIn;
    logic [1:0][W-1:0] bIn;
    logic [1:0]        ackOut;
    logic [1:0]        resReady;
    logic [1:0]        resAck;
    logic [1:0][W-1:0] resData;
    logic              gcdAReady, gcdAAck;
    logic              gcdBReady, gcdBAck;
    logic [W-1:0]      gcdAData, gcdBData;
    logic              gcdOutReady, gcdOutAck;
    logic [W-1:0]      gcdOutData;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int grantQ[$];
    int doneQ[$];
    logic [W-1:0] dataQ[$];
    int ackCnt [2];
    int reload [2];
    int resDelay [2];
    int resWait [2];
    logic resSeen [2];
    int r1Activity;
    logic autoGcd;
    int aDelay, bDelay, aWait, bWait;
    logic aGot, bGot, haveA, haveB;
    logic [W-1:0] opA, opB;

    always #5 clockInput = ~clockInput;

    gcd_arbiter #(.WIDTH(W)) dut (
        .clockInput          (clockInput),
        .resetInput          (resetInput),
        .r0IsReadyInput      (isReady[0]),
        .r0ADataInput        (aIn[0]),
        .r0BDataInput        (bIn[0]),
        .r0AckOutput         (ackOut[0]),
        .r0ResultReadyOutput (resReady[0]),
        .r0ResultDataOutput  (resData[0]),
        .r0ResultAckInput    (resAck[0]),
        .r1IsReadyInput      (isReady[1]),
        .r1ADataInput        (aIn[1]),
        .r1BDataInput        (bIn[1]),
        .r1AckOutput         (ackOut[1]),
        .r1ResultReadyOutput (resReady[1]),
        .r1ResultDataOutput  (resData[1]),
        .r1ResultAckInput    (resAck[1]),
        .gcdAIsReadyOutput   (gcdAReady),
        .gcdADataOutput      (gcdAData),
        .gcdAAckInput        (gcdAAck),
        .gcdBIsReadyOutput   (gcdBReady),
        .gcdBDataOutput      (gcdBData),
        .gcdBAckInput        (gcdBAck),
        .gcdOutReadyInput    (gcdOutReady),
        .gcdOutDataInput     (gcdOutData),
        .gcdOutAckOutput     (gcdOutAck)
    );

    function automatic logic [W-1:0] gcdFn(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int doneAt(input int i);
        return (i < doneQ.size()) ? doneQ[i] : -1;
    endfunction

    function automatic int grantAt(input int i);
        return (i < grantQ.size()) ? grantQ[i] : -1;
    endfunction

    function automatic logic [W-1:0] dataAt(input int i);
        return (i < dataQ.size()) ? dataQ[i] : '1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one negedge: observe outputs, then let the responders react
    task automatic step();
        @(negedge clockInput);
        cyc++;
        resAck  = 2'b00;
        gcdAAck = 1'b0;
        gcdBAck = 1'b0;
        if (ackOut[1] || resReady[1]) r1Activity++;
        for (int n = 0; n < 2; n++) begin
            if (ackOut[n]) begin
                grantQ.push_back(n);
                ackCnt[n]++;
                if (reload[n] > 0) reload[n]--;
                else isReady[n] = 1'b0;
            end
            if (resReady[n]) begin
                if (!resSeen[n]) begin
                    resSeen[n] = 1'b1;
                    resWait[n] = 0;
                    doneQ.push_back(n);
                    dataQ.push_back(resData[n]);
                end
                if (resWait[n] == resDelay[n]) resAck[n] = 1'b1;
                resWait[n]++;
            end else begin
                resSeen[n] = 1'b0;
            end
        end
        if (autoGcd) begin
            if (!gcdAReady) begin
                aGot = 1'b0;
                aWait = 0;
            end else if (!aGot) begin
                if (aWait >= aDelay) begin
                    gcdAAck = 1'b1;
                    aGot = 1'b1;
                    haveA = 1'b1;
                    opA = gcdAData;
                end else aWait++;
            end
            if (!gcdBReady) begin
                bGot = 1'b0;
                bWait = 0;
            end else if (!bGot) begin
                if (bWait >= bDelay) begin
                    gcdBAck = 1'b1;
                    bGot = 1'b1;
                    haveB = 1'b1;
                    opB = gcdBData;
                end else bWait++;
            end
            if (gcdOutAck) begin
                gcdOutReady = 1'b0;
            end else if (haveA && haveB && !gcdOutReady) begin
                gcdOutReady = 1'b1;
                gcdOutData = gcdFn(opA, opB);
                haveA = 1'b0;
                haveB = 1'b0;
            end
        end
    endtask

    task automatic applyReset();
        resetInput = 1'b0;
        isReady = '0;
        aIn = '0;
        bIn = '0;
        resAck = '0;
        gcdAAck = 1'b0;
        gcdBAck = 1'b0;
        gcdOutReady = 1'b0;
        gcdOutData = '0;
        grantQ.delete();
        doneQ.delete();
        dataQ.delete();
        for (int n = 0; n < 2; n++) begin
            ackCnt[n] = 0;
            reload[n] = 0;
            resDelay[n] = 0;
            resWait[n] = 0;
            resSeen[n] = 1'b0;
        end
        r1Activity = 0;
        autoGcd = 1'b1;
        aDelay = 0;
        bDelay = 0;
        aWait = 0;
        bWait = 0;
        aGot = 1'b0;
        bGot = 1'b0;
        haveA = 1'b0;
        haveB = 1'b0;
        repeat (2) step();
        resetInput = 1'b1;
        step();
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ctrl"}, {ackOut, resReady, gcdAReady,
                               gcdBReady, gcdOutAck}, 0);
        check({tag, "_res0"}, resData[0], 0);
        check({tag, "_res1"}, resData[1], 0);
        check({tag, "_opa"}, gcdAData, 0);
        check({tag, "_opb"}, gcdBData, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        applyReset();
        resetInput = 1'b0;
        #1;
        checkAllZero("reset");
        check("reset_state", dut.state, IDLE);
        check("reset_ptr", dut.pointer, 0);
        check("reset_owner", dut.owner, 0);

        // r0 alone: (12,6) -> 6
        applyReset();
        r1Activity = 0;
        aIn[0] = 12;
        bIn[0] = 6;
        isReady[0] = 1'b1;
        step();
        check("t1_grant_lat", {ackOut[0], gcdAReady, gcdBReady}, 3'b111);
        check("t1_opa", gcdAData, 12);
        check("t1_opb", gcdBData, 6);
        for (int i = 0; i < 40 && doneQ.size() < 1; i++) step();
        check("t1_done", doneQ.size(), 1);
        check("t1_owner", doneAt(0), 0);
        check("t1_data", dataAt(0), 6);
        repeat (4) step();
        check("t1_r0_acks", ackCnt[0], 1);
        check("t1_r1_idle", r1Activity, 0);
        check("t1_ptr", dut.pointer, 1);

        // both at once after reset: r0 first
        applyReset();
        aIn[0] = 8;
        bIn[0] = 12;
        aIn[1] = 14;
        bIn[1] = 28;
        isReady = 2'b11;
        for (int i = 0; i < 80 && doneQ.size() < 2; i++) step();
        check("t2_done", doneQ.size(), 2);
        check("t2_first_owner", doneAt(0), 0);
        check("t2_first_data", dataAt(0), 4);
        check("t2_second_owner", doneAt(1), 1);
        check("t2_second_data", dataAt(1), 14);

        // continuously ready: alternate grants
        applyReset();
        aIn[0] = 9;
        bIn[0] = 6;
        aIn[1] = 10;
        bIn[1] = 15;
        reload[0] = 2;
        reload[1] = 2;
        isReady = 2'b11;
        for (int i = 0; i < 200 && doneQ.size() < 6; i++) step();
        check("t3_g0", grantAt(0), 0);
        check("t3_g1", grantAt(1), 1);
        check("t3_g2", grantAt(2), 0);
        check("t3_g3", grantAt(3), 1);
        check("t3_jobs", grantQ.size(), 6);
        check("t3_d1", dataAt(1), 5);
        check("t3_d2", dataAt(2), 3);

        // operand A acked 3 cycles after B
        applyReset();
        autoGcd = 1'b0;
        aIn[0] = 21;
        bIn[0] = 14;
        isReady[0] = 1'b1;
        step();
        check("t4_both_ready", {gcdAReady, gcdBReady}, 2'b11);
        check("t4_issue", dut.state, ISSUE);
        gcdBAck = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t4_b_only_drop", {gcdAReady, gcdBReady}, 2'b10);
            check("t4_still_issue", dut.state, ISSUE);
        end
        gcdAAck = 1'b1;
        step();
        check("t4_a_drop", {gcdAReady, gcdBReady}, 2'b00);
        check("t4_wait", dut.state, WAIT_RESULT);
        gcdOutReady = 1'b1;
        gcdOutData = 7;
        step();
        check("t4_capture", {gcdOutAck, resReady}, 3'b101);
        check("t4_data", resData[0], 7);
        check("t4_deliver", dut.state, DELIVER);
        gcdOutReady = 1'b0;
        step();
        check("t4_release", {gcdOutAck, resReady}, 3'b000);
        check("t4_idle", dut.state, IDLE);

        // slow r1 result ack while r0 waits
        applyReset();
        resDelay[1] = 5;
        aIn[1] = 27;
        bIn[1] = 18;
        isReady[1] = 1'b1;
        step();
        check("t5_r1_grant", ackOut[1], 1);
        aIn[0] = 5;
        bIn[0] = 10;
        isReady[0] = 1'b1;
        for (int i = 0; i < 40 && !resReady[1]; i++) step();
        check("t5_r1_ready", resReady[1], 1);
        check("t5_r1_data", resData[1], 9);
        resAck[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t5_hold", {resReady[1], resData[1]}, {1'b1, 32'd9});
            check("t5_no_r0", ackOut[0], 0);
            check("t5_in_deliver", dut.state, DELIVER);
        end
        step();
        check("t5_exit", {resReady[1], ackOut[0]}, 2'b00);
        check("t5_idle", dut.state, IDLE);
        step();
        check("t5_r0_grant", ackOut[0], 1);
        for (int i = 0; i < 40 && doneQ.size() < 2; i++) step();
        check("t5_r0_owner", doneAt(1), 0);
        check("t5_r0_data", dataAt(1), 5);

        // reset during WAIT_RESULT, then a late result
        applyReset();
        autoGcd = 1'b0;
        aIn[0] = 16;
        bIn[0] = 12;
        isReady[0] = 1'b1;
        step();
        gcdAAck = 1'b1;
        gcdBAck = 1'b1;
        step();
        check("t6_wait", dut.state, WAIT_RESULT);
        resetInput = 1'b0;
        #1;
        checkAllZero("t6_rst");
        check("t6_rst_state", dut.state, IDLE);
        step();
        gcdOutReady = 1'b1;
        gcdOutData = 9;
        step();
        check("t6_rst_noack", {gcdOutAck, resReady}, 3'b000);
        resetInput = 1'b1;
        aIn[1] = 30;
        bIn[1] = 45;
        isReady[1] = 1'b1;
        step();
        check("t6_drain", {gcdOutAck, resReady, ackOut[1]}, 4'b1000);
        gcdOutReady = 1'b0;
        autoGcd = 1'b1;
        step();
        check("t6_grant_after", {gcdOutAck, ackOut[1]}, 2'b01);
        for (int i = 0; i < 40 && doneQ.size() < 1; i++) step();
        repeat (3) step();
        check("t6_deliveries", doneQ.size(), 1);
        check("t6_owner", doneAt(0), 1);
        check("t6_data", dataAt(0), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
